// File: rtl/spell_mem_master.sv
// ---------------------------------------------------------------------------
// spell_mem_master: single-outstanding memory access master (IDLE/BUSY/RELEASE)
// Optional BUSY timeout is enabled with macro SPELL_MEM_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spell_mem_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_data_space,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_error,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_write,
  output logic       mem_type_data,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("spell_mem_master: TIMEOUT_CYCLES must be within 1..255");
  end

  state_t r_state;

  assign req_ready = (r_state == IDLE);

`ifdef SPELL_MEM_TIMEOUT_EN
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_tmo_cnt;
`else
  assign resp_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      mem_select    <= 1'b0;
      mem_write     <= 1'b0;
      mem_type_data <= 1'b0;
      mem_addr      <= 8'h00;
      mem_wdata     <= 8'h00;
      resp_valid    <= 1'b0;
      resp_rdata    <= 8'h00;
`ifdef SPELL_MEM_TIMEOUT_EN
      resp_error    <= 1'b0;
      r_tmo_cnt     <= 8'h00;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            mem_addr      <= req_addr;
            mem_wdata     <= req_wdata;
            mem_write     <= req_write;
            mem_type_data <= req_data_space;
            mem_select    <= 1'b1;
`ifdef SPELL_MEM_TIMEOUT_EN
            r_tmo_cnt     <= 8'h00;
`endif
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          // A ready responder wins over a timeout reached in the same cycle
          if (mem_ready) begin
            mem_select <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= mem_write ? 8'h00 : mem_rdata;
`ifdef SPELL_MEM_TIMEOUT_EN
            resp_error <= 1'b0;
`endif
            r_state    <= RELEASE;
          end
`ifdef SPELL_MEM_TIMEOUT_EN
          else if (r_tmo_cnt == C_TMO_LAST) begin
            mem_select <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= 8'h00;
            resp_error <= 1'b1;
            r_tmo_cnt  <= r_tmo_cnt + 8'd1;
            r_state    <= RELEASE;
          end else begin
            r_tmo_cnt  <= r_tmo_cnt + 8'd1;
          end
`endif
        end
        RELEASE: begin
          // One dead cycle lets the responder drop mem_ready before the next access
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          mem_select <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spell_mem_master.sv
// ---------------------------------------------------------------------------
// tb_spell_mem_master: scoreboard bench for spell_mem_master with a
// configurable-wait responder model. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spell_mem_master;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic       req_data_space = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready, resp_valid, resp_error;
  logic [7:0] resp_rdata;
  logic       mem_select, mem_write, mem_type_data;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;

  spell_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_data_space(req_data_space), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_type_data(mem_type_data),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: raises ready wait_cycles edges after first seeing select, holds it while select is high
  int         wait_cycles = 0;
  bit         never_ready = 1'b0;
  bit         force_ready = 1'b0;
  logic [7:0] salt = 8'h00;
  int         rcnt = 0;
  logic       rdy_r = 1'b0;

  always @(posedge clk) begin
    if (mem_select !== 1'b1) begin
      rcnt  <= 0;
      rdy_r <= 1'b0;
    end else if (!never_ready) begin
      if (rcnt >= wait_cycles) rdy_r <= 1'b1;
      else                     rcnt  <= rcnt + 1;
    end
  end

  assign mem_ready = rdy_r | force_ready;
  assign mem_rdata = mem_ready ? (mem_addr ^ salt) : 8'hEE;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic scoreboard_monitor();
    bit   prev_resp = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        vectors++;
        if (prev_resp) begin
          miscompares++;
          $display("FAIL resp_double: resp_valid high two cycles in a row at cycle %0d", cyc);
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected: got pulse rdata=%h err=%b, required none", resp_rdata, resp_error);
        end else begin
          e = exp_q.pop_front();
          if (resp_rdata !== e.rdata || resp_error !== e.err) begin
            miscompares++;
            $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                     resp_rdata, resp_error, e.rdata, e.err);
          end
        end
      end
      prev_resp = (resp_valid === 1'b1);
    end
  endtask

  // Drives one request and returns the rising-edge count at which it was accepted
  task automatic issue(input bit w, input bit ds, input logic [7:0] a, input logic [7:0] wd,
                       input bit push, input exp_t e, output int acc);
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
    end
    req_write = w; req_data_space = ds; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        at = cyc;
        return;
      end
    end
    vectors++; miscompares++;
    $display("FAIL resp_wait: no resp_valid within 60 cycles, required a pulse");
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_addr = 8'h77; req_wdata = 8'h99; req_write = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({mem_select, mem_write, mem_type_data, resp_valid, resp_error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: sel/wr/type/rv/err=%b, required 00000",
               {mem_select, mem_write, mem_type_data, resp_valid, resp_error});
    end
    vectors++;
    if (mem_addr !== 8'h00 || mem_wdata !== 8'h00 || resp_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required 00 00 00", mem_addr, mem_wdata, resp_rdata);
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || mem_select !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: req_ready=%b mem_select=%b, required 1 0", req_ready, mem_select);
    end
  endtask

  task automatic test_zero_wait_read();
    int acc, at;
    wait_cycles = 0; salt = 8'hA6;
    issue(1'b0, 1'b1, 8'h03, 8'h00, 1'b1, '{rdata: 8'hA5, err: 1'b0}, acc);
    @(negedge clk);
    vectors++;
    if (mem_select !== 1'b1 || mem_addr !== 8'h03 || mem_type_data !== 1'b1 || mem_write !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zw_busy: sel=%b addr=%h type=%b wr=%b rdy=%b, required 1 03 1 0 0",
               mem_select, mem_addr, mem_type_data, mem_write, req_ready);
    end
    wait_resp(at);
    vectors++;
    if (at - acc != 2) begin
      miscompares++;
      $display("FAIL zw_latency: resp %0d edges after accept, required 2", at - acc);
    end
    vectors++;
    if (mem_select !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zw_release: sel=%b rdy=%b, required 0 0", mem_select, req_ready);
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zw_idle: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_write_wait();
    int acc, at;
    bit bad = 1'b0;
    wait_cycles = 3; salt = 8'h3C;
    issue(1'b1, 1'b0, 8'h1F, 8'h5A, 1'b1, '{rdata: 8'h00, err: 1'b0}, acc);
    req_addr = 8'hC0; req_wdata = 8'h01; req_write = 1'b0; req_data_space = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_select !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 8'h1F ||
          mem_wdata !== 8'h5A || mem_type_data !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL wr_hold: mem_* not held, last sel=%b wr=%b addr=%h wdata=%h, required 1 1 1f 5a",
               mem_select, mem_write, mem_addr, mem_wdata);
    end
    wait_resp(at);
    vectors++;
    if (at - acc != 5) begin
      miscompares++;
      $display("FAIL wr_latency: resp %0d edges after accept, required 5", at - acc);
    end
  endtask

  task automatic test_back_to_back();
    int acc[3], rsp[3];
    int n = 0, nr = 0, rel = 0;
    wait_cycles = 0; salt = 8'h11;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 && nr < 3) begin rsp[nr] = cyc; nr++; end
      if (mem_select === 1'b0 && req_ready === 1'b0) rel++;
      if (req_ready === 1'b1 && n < 3) begin
        req_write = 1'b0; req_data_space = 1'b1; req_addr = 8'h20 + 8'(n); req_valid = 1'b1;
        exp_q.push_back('{rdata: (8'h20 + 8'(n)) ^ 8'h11, err: 1'b0});
        acc[n] = cyc + 1;
        n++;
      end else if (req_ready === 1'b0 && n == 3) begin
        req_valid = 1'b0;
      end
    end
    vectors++;
    if (nr != 3) begin
      miscompares++;
      $display("FAIL b2b_count: %0d responses, required 3", nr);
    end else begin
      vectors++;
      if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
        miscompares++;
        $display("FAIL b2b_accept: spacing %0d %0d, required 4 4", acc[1] - acc[0], acc[2] - acc[1]);
      end
      vectors++;
      if (rsp[1] - rsp[0] != 4 || rsp[2] - rsp[1] != 4 || rsp[0] - acc[0] != 2) begin
        miscompares++;
        $display("FAIL b2b_resp: spacing %0d %0d first %0d, required 4 4 2",
                 rsp[1] - rsp[0], rsp[2] - rsp[1], rsp[0] - acc[0]);
      end
    end
    vectors++;
    if (rel != 3) begin
      miscompares++;
      $display("FAIL b2b_release: %0d release cycles, required 3", rel);
    end
  endtask

  task automatic test_timeout();
    int acc, at;
    wait_cycles = 0; salt = 8'h55; never_ready = 1'b1;
`ifdef SPELL_MEM_TIMEOUT_EN
    issue(1'b0, 1'b1, 8'h44, 8'h00, 1'b1, '{rdata: 8'h00, err: 1'b1}, acc);
    wait_resp(at);
    vectors++;
    if (at - acc != TO) begin
      miscompares++;
      $display("FAIL tmo_latency: resp %0d edges after accept, required %0d", at - acc, TO);
    end
    never_ready = 1'b0;
`else
    begin
      bit bad = 1'b0;
      issue(1'b0, 1'b1, 8'h44, 8'h00, 1'b1, '{rdata: 8'h44 ^ 8'h55, err: 1'b0}, acc);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (mem_select !== 1'b1 || resp_valid !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL notmo_wait: sel=%b resp_valid=%b, required 1 0 throughout", mem_select, resp_valid);
      end
      never_ready = 1'b0;
      wait_resp(at);
    end
`endif
    issue(1'b0, 1'b0, 8'h0F, 8'h00, 1'b1, '{rdata: 8'h0F ^ 8'h55, err: 1'b0}, acc);
    wait_resp(at);
    vectors++;
    if (at - acc != 2) begin
      miscompares++;
      $display("FAIL tmo_next: resp %0d edges after accept, required 2", at - acc);
    end
  endtask

  task automatic test_reset_abort();
    int acc;
    wait_cycles = 3; salt = 8'h00;
    issue(1'b0, 1'b1, 8'h66, 8'h00, 1'b0, '{rdata: 8'h00, err: 1'b0}, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_select !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_sel: sel=%b resp_valid=%b, required 0 0", mem_select, resp_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_ready: req_ready=%b, required 1", req_ready);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_spurious();
    int acc, at;
    bit bad = 1'b0;
    wait_cycles = 2; salt = 8'h0A;
    @(negedge clk);
    force_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_select !== 1'b0) bad = 1'b1;
    end
    force_ready = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL idle_ready: activity with mem_ready forced in IDLE, rv=%b rdy=%b sel=%b, required 0 1 0",
               resp_valid, req_ready, mem_select);
    end
    bad = 1'b0;
    issue(1'b0, 1'b1, 8'h40, 8'h00, 1'b1, '{rdata: 8'h40 ^ 8'h0A, err: 1'b0}, acc);
    @(negedge clk);
    req_addr = 8'hBB; req_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (mem_select === 1'b1 && (mem_addr !== 8'h40 || mem_write !== 1'b0)) bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL mid_busy_addr: mem_addr=%h mem_write=%b, required 40 0", mem_addr, mem_write);
    end
    wait_resp(at);
    vectors++;
    if (at - acc != 4) begin
      miscompares++;
      $display("FAIL mid_busy_latency: resp %0d edges after accept, required 4", at - acc);
    end
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_back_to_back();
    test_timeout();
    test_reset_abort();
    test_spurious();
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spell_mem_master.md
SPELL_MEM_MASTER -- requirements
Module: spell_mem_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16; BUSY cycles without mem_ready before abort (range 1..255).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  requester has an access pending.
REQ-006 req_ready  output  1  block accepts a request this cycle; high exactly when state is IDLE.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_data_space  input  1  1 = data memory, 0 = code memory.
REQ-009 req_addr  input  8  access address.
REQ-010 req_wdata  input  8  write data.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  8  read data; valid with resp_valid.
REQ-013 resp_error  output  1  access timed out; valid with resp_valid.
REQ-014 mem_select  output  1  memory access strobe to responder.
REQ-015 mem_addr / mem_wdata  output  8 each  address and write data to responder.
REQ-016 mem_write / mem_type_data  output  1 each  write enable and space select to responder.
REQ-017 mem_rdata  input  8  responder read data.
REQ-018 mem_ready  input  1  responder completion; stays high while mem_select high.

Function
REQ-019 States SHALL be IDLE, BUSY, RELEASE.
REQ-020 IDLE: on req_valid&&req_ready, latch req_* into mem_addr/mem_wdata/mem_write/mem_type_data, set mem_select=1, clear timeout counter, go BUSY.
REQ-021 req_* changes after acceptance SHALL have no effect on the in-flight access.
REQ-022 BUSY: mem_select=1 and mem_* held stable; on first cycle mem_ready=1, go RELEASE, set mem_select=0, and pulse resp_valid=1 with resp_error=0 in the next cycle.
REQ-023 resp_rdata SHALL be mem_rdata sampled that cycle for reads and 8'h00 for writes; it holds until the next response.
REQ-024 RELEASE: mem_select=0 for exactly one cycle, mem_ready ignored, then IDLE; this guarantees the responder's ready has cleared before the next access.
REQ-025 mem_ready SHALL be ignored in IDLE and RELEASE.
REQ-026 Latency, zero-wait responder: accept at edge E; mem_select high cycle E+1; resp_valid cycle E+3; req_ready high again cycle E+4; back-to-back throughput one access per 4 cycles.
REQ-027 resp_valid SHALL never be high for two consecutive cycles, and SHALL pulse once per accepted request, except when rst aborts the access.

Reset
REQ-028 rst SHALL force IDLE; mem_select=0, mem_write=0, mem_type_data=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_error=0, resp_rdata=0, timeout counter=0.
REQ-029 req_valid during a rst cycle SHALL be ignored; req_ready SHALL be high from the first cycle after rst deasserts.
REQ-030 rst in BUSY or RELEASE SHALL abort the access with no resp_valid pulse, and mem_select SHALL be low from the next cycle.

Configuration
REQ-031 With SPELL_MEM_TIMEOUT_EN defined: the counter increments each BUSY cycle with mem_ready=0. On reaching TIMEOUT_CYCLES, the block goes RELEASE, mem_select=0, and pulses resp_valid with resp_error=1, resp_rdata=0.
REQ-032 With SPELL_MEM_TIMEOUT_EN defined, mem_ready=1 in the same cycle the count is reached SHALL complete normally with resp_error=0.
REQ-033 Without SPELL_MEM_TIMEOUT_EN: no counter is built, BUSY waits indefinitely, and resp_error is tied to 0.

Verification
REQ-034 Zero-wait read, req_data_space=1, addr 8'h03, mem_rdata 8'hA5 -> resp_valid at E+3, resp_rdata=8'hA5, resp_error=0.
REQ-035 Write, code space, addr 8'h1F, wdata 8'h5A, responder 3 wait cycles -> mem_write=1, mem_addr=8'h1F held every BUSY cycle; resp_rdata=8'h00; resp_valid 3 cycles later than in REQ-034.
REQ-036 req_valid held high for 3 reads -> mem_select low exactly one cycle between accesses; resp_valid pulses 4 cycles apart.
REQ-037 With SPELL_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, responder never ready -> resp_valid with resp_error=1 after 16 BUSY cycles, then IDLE; the next normal read succeeds.
REQ-038 rst asserted in the second BUSY cycle -> no resp_valid pulse, mem_select=0 next cycle, req_ready=1 the cycle after rst deasserts.
REQ-039 mem_ready forced high while IDLE, and req_addr changed mid-BUSY -> no spurious resp_valid; mem_addr keeps the latched value.
